// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: Gray conversions
// sized for the widest legal pointer, and the depth derivation.
package fifo_pkg;

  localparam int MAX_PTR_W = 13;

  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_level_if.sv
// Write-side bus between the FIFO writer/memory port and the write pointer block.
// Handshake: a write is taken on a wclk edge when winc=1 and full=0 (wen=1); winc while full is dropped and flagged on wovf.
interface wptr_full_level_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  winc;
  logic                  wovf_clr;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  wen;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  wovf;

  modport master (
    output winc, wovf_clr, rptr_gray,
    input  waddr, wptr_gray, wen, full, almost_full, wlevel, wovf
  );

  modport slave (
    input  winc, wovf_clr, rptr_gray,
    output waddr, wptr_gray, wen, full, almost_full, wlevel, wovf
  );
endinterface

// File: rtl/sync_bus_ff.sv
// Multi-stage flop chain for bringing a Gray-coded bus into a new clock domain.
module sync_bus_ff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer, full/almost-full, fill level and sticky overflow for the
// dual-clock FIFO. Status is pessimistic: read progress arrives through the synchroniser.
module wptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input logic              wclk,
  input logic              wrst_n,
  wptr_full_level_if.slave bus
);

  localparam int PW        = ADDR_WIDTH + 1;
  localparam int DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam int AFULL_EFF = (AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH;
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_EFF);

  logic [PW-1:0] wbin, wgray, wlevel_q;
  logic [PW-1:0] wbin_next, wgray_next, rq_sync, rbin_sync, level_next;
  logic          full_q, afull_q, wovf_q, wen;

  sync_bus_ff #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_rsync (
    .clk  (wclk),
    .rst_n(wrst_n),
    .d    (bus.rptr_gray),
    .q    (rq_sync)
  );

  assign wen        = bus.winc & ~full_q;
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = PW'(bin2gray(ptr_t'(wbin_next)));
  assign rbin_sync  = PW'(gray2bin(ptr_t'(rq_sync)));
  assign level_next = wbin_next - rbin_sync;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin     <= '0;
      wgray    <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wgray    <= wgray_next;
      wlevel_q <= level_next;
      // Full when the write pointer has lapped the read pointer by exactly one wrap.
      full_q   <= (wgray_next == {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]});
      afull_q  <= (level_next >= AFULL_T);
      if (bus.winc && full_q)  wovf_q <= 1'b1;
      else if (bus.wovf_clr)   wovf_q <= 1'b0;
    end
  end

  assign bus.waddr       = wbin[ADDR_WIDTH-1:0];
  assign bus.wptr_gray   = wgray;
  assign bus.wen         = wen;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wlevel      = wlevel_q;
  assign bus.wovf        = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed bench for wptr_full_level: a default instance and a small-width instance.
module tb_wptr_full_level;

  logic wclk;
  logic wrst_n;
  int   n_checks;
  int   n_fail;

  wptr_full_level_if #(.ADDR_WIDTH(4)) a_if ();
  wptr_full_level_if #(.ADDR_WIDTH(2)) b_if ();

  wptr_full_level #(
    .ADDR_WIDTH  (4),
    .SYNC_STAGES (2),
    .AFULL_THRESH(12)
  ) dut_a (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (a_if.slave)
  );

  wptr_full_level #(
    .ADDR_WIDTH  (2),
    .SYNC_STAGES (3),
    .AFULL_THRESH(4)
  ) dut_b (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (b_if.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
  endtask

  int wcnt, rbin, rs1, rs2, exp_level;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wrst_n   = 1'b0;
    a_if.winc = 1'b0; a_if.wovf_clr = 1'b0; a_if.rptr_gray = '0;
    b_if.winc = 1'b0; b_if.wovf_clr = 1'b0; b_if.rptr_gray = '0;
    #1;
    check("rst_waddr", 32'(a_if.waddr), 0);
    check("rst_wptr_gray", 32'(a_if.wptr_gray), 0);
    check("rst_full", 32'(a_if.full), 0);
    check("rst_afull", 32'(a_if.almost_full), 0);
    check("rst_wlevel", 32'(a_if.wlevel), 0);
    check("rst_wovf", 32'(a_if.wovf), 0);
    tick(); tick();
    wrst_n = 1'b1;

    // A few writes, then reset in the middle of a cycle with winc held.
    a_if.winc = 1'b1;
    tick(); tick(); tick();
    check("pre_rst_wlevel", 32'(a_if.wlevel), 3);
    check("pre_rst_waddr", 32'(a_if.waddr), 3);
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    check("mid_rst_waddr", 32'(a_if.waddr), 0);
    check("mid_rst_wptr_gray", 32'(a_if.wptr_gray), 0);
    check("mid_rst_wlevel", 32'(a_if.wlevel), 0);
    tick();
    wrst_n = 1'b1;
    check("post_rst_waddr", 32'(a_if.waddr), 0);
    check("post_rst_wen", 32'(a_if.wen), 1);
    tick();
    check("post_rst_wlevel", 32'(a_if.wlevel), 1);
    check("post_rst_waddr1", 32'(a_if.waddr), 1);
    a_if.winc = 1'b0;
    do_reset();

    // Fill to full with the read pointer parked at 0.
    a_if.winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("fill_waddr", 32'(a_if.waddr), 32'(i - 1));
      tick();
      check("fill_wlevel", 32'(a_if.wlevel), 32'(i));
      check("fill_afull", 32'(a_if.almost_full), (i >= 12) ? 1 : 0);
      check("fill_full", 32'(a_if.full), (i == 16) ? 1 : 0);
    end
    check("ovf_wen", 32'(a_if.wen), 0);
    check("ovf_waddr", 32'(a_if.waddr), 0);
    tick();
    check("ovf_wovf", 32'(a_if.wovf), 1);
    check("ovf_wlevel", 32'(a_if.wlevel), 16);
    check("ovf_waddr_hold", 32'(a_if.waddr), 0);

    // Set beats clear, then a lone clear drops the flag.
    a_if.wovf_clr = 1'b1;
    tick();
    check("ovf_set_wins", 32'(a_if.wovf), 1);
    a_if.winc = 1'b0;
    tick();
    check("ovf_clear", 32'(a_if.wovf), 0);
    a_if.wovf_clr = 1'b0;

    // One read frees a slot; visible three edges later, not sooner.
    a_if.rptr_gray = 5'(gray(1));
    tick();
    check("drain_full_e1", 32'(a_if.full), 1);
    tick();
    check("drain_full_e2", 32'(a_if.full), 1);
    check("drain_wlevel_e2", 32'(a_if.wlevel), 16);
    tick();
    check("drain_full_e3", 32'(a_if.full), 0);
    check("drain_wlevel_e3", 32'(a_if.wlevel), 15);
    check("drain_afull_e3", 32'(a_if.almost_full), 1);

    // Wrap-around: reader trails the writer closely through 40 writes.
    a_if.rptr_gray = '0;
    do_reset();
    wcnt = 0; rs1 = 0; rs2 = 0;
    a_if.winc = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      rbin = (wcnt >= 1) ? (wcnt - 1) % 32 : 0;
      a_if.rptr_gray = 5'(gray(rbin));
      tick();
      exp_level = (wcnt + 1 - rs2) & 31;
      rs2 = rs1;
      rs1 = rbin;
      wcnt++;
      check("wrap_wlevel", 32'(a_if.wlevel), 32'(exp_level));
      check("wrap_full", 32'(a_if.full), 0);
      if (k >= 5)
        check("wrap_level_band", 32'((a_if.wlevel == 5'd4) || (a_if.wlevel == 5'd5)), 1);
    end
    a_if.winc = 1'b0;
    check("wrap_wptr_gray", 32'(a_if.wptr_gray), 32'(gray(8)));
    check("wrap_waddr", 32'(a_if.waddr), 8);

    // Narrow instance: full and almost_full together on the 4th write.
    b_if.winc = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("b_wlevel", 32'(b_if.wlevel), 32'(i));
      check("b_full", 32'(b_if.full), (i == 4) ? 1 : 0);
      check("b_afull", 32'(b_if.almost_full), (i == 4) ? 1 : 0);
    end
    b_if.winc = 1'b0;
    b_if.rptr_gray = 3'(gray(1));
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("b_release_hold", 32'(b_if.full), 1);
    end
    tick();
    check("b_release_full", 32'(b_if.full), 0);
    check("b_release_wlevel", 32'(b_if.wlevel), 3);
    check("b_release_afull", 32'(b_if.almost_full), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wptr_full_level.md
# wptr_full_level

Write-side pointer and status block for the dual-clock FIFO, running in the write clock domain. It generalises the basic write-pointer/full generator with:
- an internal parametrised synchroniser for the incoming read pointer;
- a fill-level count and a programmable almost-full flag;
- a sticky overflow flag with clear.

It sits between the FIFO memory write port and the read-domain pointer logic.

## Interface
- ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH; legal range 2..12
- SYNC_STAGES, 2, synchroniser flops on rptr_gray; legal range 2..4
- AFULL_THRESH, 12, almost_full asserts when level >= this; legal range 1..DEPTH
- wclk  input  1  write clock
- wrst_n  input  1  asynchronous active-low reset, deasserted synchronously to wclk externally
- winc  input  1  write request
- wovf_clr  input  1  clears the overflow flag
- rptr_gray  input  ADDR_WIDTH+1  Gray read pointer from the read domain, asynchronous to wclk
- waddr  output  ADDR_WIDTH  memory write address for the current cycle
- wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, to the read domain
- wen  output  1  memory write enable, combinational: winc & ~full
- full  output  1  registered full flag
- almost_full  output  1  registered, level >= AFULL_THRESH
- wlevel  output  ADDR_WIDTH+1  registered fill level as seen from the write domain, 0..DEPTH
- wovf  output  1  sticky: a write was attempted while full

## Operation
- Internal state:
  - wbin, ADDR_WIDTH+1 bits;
  - wgray register;
  - SYNC_STAGES-deep rq shift register;
  - full, almost_full, wlevel, wovf registers.
- A write is accepted on a wclk edge when winc=1 and full=0.
  - The memory writes at waddr = wbin[ADDR_WIDTH-1:0] in that cycle.
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1); wrap-around is natural.
- wgray_next = (wbin_next >> 1) ^ wbin_next. Both wbin and wptr_gray load on every edge.
- rq_sync is the last stage of the synchroniser. rbin_sync = Gray-to-binary of rq_sync.
- Full compare: full <= (wgray_next == {~rq_sync[AW:AW-1], rq_sync[AW-2:0]}).
- Level: level_next = wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1). It never exceeds DEPTH.
  - wlevel <= level_next.
  - almost_full <= (level_next >= AFULL_THRESH).
- Overflow: on winc & full, wovf <= 1. Otherwise, on wovf_clr, wovf <= 0.
  - If both events occur in the same cycle, set wins.
  - An overflow write is dropped: no address advance and wen=0.
- Reset values, applied asynchronously:
  - wbin, wptr_gray, rq stages, wlevel = 0;
  - full, almost_full, wovf = 0;
  - waddr = 0.
- Reset mid-operation discards all pointer state immediately. The read domain must be reset in the same event.

## Timing
- Write-to-status latency is one edge. After the edge accepting the write that reaches DEPTH, full=1 and wlevel=DEPTH in the same cycle.
- wptr_gray changes at most one bit per edge and is glitch-free, because it is registered.
- A read-pointer change is visible in full/wlevel/almost_full after SYNC_STAGES+1 wclk edges. Status is therefore pessimistic: full may remain asserted after space frees, but it is never falsely deasserted.
- winc is sampled every edge. There is no backpressure beyond full; the writer must gate on full or accept dropped writes, which are flagged by wovf.
- A write while not full and a rptr change in the same cycle are both applied. The level reflects the write immediately and the read after synchronisation.

## Structure
- Shared package fifo_pkg holds:
  - function bin2gray(width-generic via ADDR_WIDTH+1);
  - function gray2bin, implemented as an XOR prefix reduction;
  - localparam DEPTH derivation.
- Sub-module sync_bus_ff: a SYNC_STAGES-deep, width-parametrised flop chain with async active-low reset. It is reused by the read-side counterpart.
- All other logic is flat in wptr_full_level.

## Test plan
- **Reset:** assert wrst_n=0 mid-cycle with winc=1 → all outputs are 0 immediately, and after release the first write goes to waddr=0.
- **Fill** (AW=4, rptr_gray=0, winc held for 17 cycles):
  - almost_full rises after the 12th write and full rises after the 16th;
  - wlevel=16;
  - the 17th request gives wen=0, waddr stays 0, and wovf=1.
- **Drain release:** from full, step rptr_gray to bin2gray(1) → full clears and wlevel=15 exactly 3 edges later (SYNC_STAGES=2). It must not clear earlier.
- **Wrap-around:** 40 writes with rptr_gray tracking 4 writes behind → wptr_gray equals bin2gray(40 mod 32), full never asserts, and wlevel is 4 or 5 throughout.
- **Overflow clear priority:** while full, winc=1 and wovf_clr=1 in the same cycle → wovf stays 1. Then wovf_clr alone → wovf=0.
- **Parameter sweep:** ADDR_WIDTH=2, SYNC_STAGES=3, AFULL_THRESH=4 → full and almost_full rise together on the 4th write, and release latency is 4 edges.
